aes_job_sched: RTL and testbench

- Schedules encrypt/decrypt jobs from NUM_REQ requesters (CPU MMIO, DMA, …) onto the single shared AES engine.
- Round-robin arbitration between requesters.
- Drives the engine's 3-bit control word, waits for its completion flag and bounds each job with a timeout.
- Forces the control word to zero between jobs so the engine clears its buffer counters, then returns a per-requester done pulse with a status code.

---
 rtl/aes_job_sched_pkg.sv | 30 +++
 rtl/aes_job_sched_if.sv | 26 ++
 rtl/aes_job_sched_rr_arbiter.sv | 36 +++
 rtl/aes_job_sched.sv | 169 ++++++++++++++++
 tb/tb_aes_job_sched.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_job_sched_pkg.sv
// Shared types and constants for the AES job scheduler: FSM states, status codes,
// request modes and engine control-word bit positions.
package aes_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        RUN,
        DRAIN,
        RESP
    } state_e;

    typedef logic [1:0] status_t;

    localparam status_t ST_OK       = 2'b00;
    localparam status_t ST_TIMEOUT  = 2'b01;
    localparam status_t ST_BAD_MODE = 2'b10;

    localparam logic [1:0] MODE_ENC = 2'b01;
    localparam logic [1:0] MODE_DEC = 2'b10;

    localparam int CTRL_W       = 3;
    localparam int CTRL_ENC_BIT = 0;
    localparam int CTRL_DEC_BIT = 1;

    function automatic logic mode_is_legal(input logic [1:0] mode);
        return (mode == MODE_ENC) || (mode == MODE_DEC);
    endfunction

endpackage

// File: rtl/aes_job_sched_if.sv
// Requester-side job handshake: per-requester valid/mode/ready plus done pulse and status.
interface aes_job_sched_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid_in;
    logic [2*NUM_REQ-1:0] req_mode_in;
    logic [NUM_REQ-1:0]   req_ready_out;
    logic [NUM_REQ-1:0]   done_valid_out;
    logic [1:0]           done_status_out;

    modport master (
        output req_valid_in,
        output req_mode_in,
        input  req_ready_out,
        input  done_valid_out,
        input  done_status_out
    );

    modport slave (
        input  req_valid_in,
        input  req_mode_in,
        output req_ready_out,
        output done_valid_out,
        output done_status_out
    );
endinterface

// File: rtl/aes_job_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins, else the
// lowest requester below ptr (wrap-around). The pointer itself is kept by the caller.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);
    logic found;

    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (en && !found && req[i] && (i >= int'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (en && !found && req[i] && (i < int'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/aes_job_sched.sv
// Schedules encrypt/decrypt jobs from NUM_REQ requesters onto one shared AES engine,
// with round-robin arbitration, a per-job timeout and a forced control-word clear gap.
module aes_job_sched
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CLR_CYCLES     = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    aes_job_sched_if.slave    req_if,
    output logic [CTRL_W-1:0] aes_ctrl_out,
    input  logic              aes_complete_in,
    input  logic              aes_ctrl_init_in,
    output logic              busy_out,
    output logic [2:0]        grant_id_out
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CLR_W = $clog2(CLR_CYCLES + 1);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLR_CYCLES - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [2:0]          grant_q, grant_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    status_t             status_q, status_d;
    logic [NUM_REQ-1:0]  done_valid_q, done_valid_d;
    status_t             done_status_q, done_status_d;
    logic                busy_q, busy_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic [1:0]          acc_mode;
    logic                accept;
    logic                run_done;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (req_if.req_valid_in),
        .ptr (rr_ptr_q),
        .en  (state_q == IDLE),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        acc_mode = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) acc_mode = req_if.req_mode_in[2*i +: 2];
        end
    end

    assign accept   = |arb_gnt;
    // Completion takes priority: a timeout only counts when complete is absent.
    assign run_done = aes_complete_in || (tmo_cnt_q == TMO_LAST);

    // NOTE: state flops use non-blocking assignments so every register samples
    // pre-edge values; async reset clears the control word mid-job without a clock.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            ctrl_q        <= '0;
            status_q      <= ST_OK;
            done_valid_q  <= '0;
            done_status_q <= ST_OK;
            busy_q        <= 1'b0;
            tmo_cnt_q     <= '0;
            clr_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            ctrl_q        <= ctrl_d;
            status_q      <= status_d;
            done_valid_q  <= done_valid_d;
            done_status_q <= done_status_d;
            busy_q        <= busy_d;
            tmo_cnt_q     <= tmo_cnt_d;
            clr_cnt_q     <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = mode_is_legal(acc_mode) ? ISSUE : RESP;
            ISSUE:   state_d = aes_ctrl_init_in ? RUN : DRAIN;
            RUN:     if (run_done) state_d = DRAIN;
            DRAIN:   if (clr_cnt_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        ctrl_d        = ctrl_q;
        status_d      = status_q;
        tmo_cnt_d     = tmo_cnt_q;
        clr_cnt_d     = clr_cnt_q;
        done_valid_d  = '0;
        done_status_d = done_status_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    grant_d = 3'(arb_idx);
                    if (mode_is_legal(acc_mode)) begin
                        ctrl_d               = '0;
                        ctrl_d[CTRL_ENC_BIT] = (acc_mode == MODE_ENC);
                        ctrl_d[CTRL_DEC_BIT] = (acc_mode == MODE_DEC);
                    end else begin
                        status_d = ST_BAD_MODE;
                    end
                end
            end
            ISSUE: begin
                tmo_cnt_d = '0;
                if (!aes_ctrl_init_in) begin
                    // Engine never decoded the control word: treat as a fault.
                    status_d  = ST_TIMEOUT;
                    ctrl_d    = '0;
                    clr_cnt_d = CLR_LOAD;
                end
            end
            RUN: begin
                if (tmo_cnt_q != TMO_SAT) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (run_done) begin
                    status_d  = aes_complete_in ? ST_OK : ST_TIMEOUT;
                    ctrl_d    = '0;
                    clr_cnt_d = CLR_LOAD;
                end
            end
            DRAIN: begin
                if (clr_cnt_q != '0) clr_cnt_d = clr_cnt_q - CLR_W'(1);
            end
            RESP: begin
                rr_ptr_d = IDX_W'((int'(grant_q) + 1) % NUM_REQ);
            end
            default: ;
        endcase

        if (state_d == RESP) begin
            done_valid_d  = NUM_REQ'(1) << grant_d;
            done_status_d = status_d;
        end
        busy_d = (state_d != IDLE);
    end

    assign req_if.req_ready_out   = arb_gnt;
    assign req_if.done_valid_out  = done_valid_q;
    assign req_if.done_status_out = done_status_q;
    assign aes_ctrl_out           = ctrl_q;
    assign busy_out               = busy_q;
    assign grant_id_out           = grant_q;

endmodule

// File: tb/tb_aes_job_sched.sv
// Directed bench for aes_job_sched: expected done pulses are queued at accept time and
// popped by a monitor when the DUT pulses done; control word and latency checked inline.
module tb_aes_job_sched;
    import aes_sched_pkg::*;

    localparam int NUM_REQ        = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int CLR_CYCLES     = 2;
    localparam int MODE_W         = 2 * NUM_REQ;

    typedef struct {
        int      idx;
        status_t st;
        int      cyc;
    } exp_t;

    logic       clk_in;
    logic       rst_n_in;
    logic [2:0] aes_ctrl_out;
    logic       aes_complete_in;
    logic       aes_ctrl_init_in;
    logic       busy_out;
    logic [2:0] grant_id_out;
    logic       init_fault;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    aes_job_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

    aes_job_sched #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CLR_CYCLES     (CLR_CYCLES)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .req_if           (bus),
        .aes_ctrl_out     (aes_ctrl_out),
        .aes_complete_in  (aes_complete_in),
        .aes_ctrl_init_in (aes_ctrl_init_in),
        .busy_out         (busy_out),
        .grant_id_out     (grant_id_out)
    );

    // Engine model: control-word decode is simply "word nonzero" unless a fault is injected.
    assign aes_ctrl_init_in = (aes_ctrl_out != 3'b000) && !init_fault;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n_in && (bus.done_valid_out != '0)) begin
            if (sb_q.size() == 0) begin
                check("done_unexpected", 32'(bus.done_valid_out), 32'(0));
            end else begin
                e = sb_q.pop_front();
                check("done_vec", 32'(bus.done_valid_out), 32'(1) << e.idx);
                check("done_status", 32'(bus.done_status_out), 32'(e.st));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // One legal job from requester idx; n_run = RUN cycles before complete (0 = never).
    task automatic job(input int idx, input logic [1:0] mode, input int n_run,
                       input status_t exp_st);
        int t;
        int done_cyc;
        logic [2:0] exp_ctrl;
        exp_ctrl = {1'b0, mode};
        bus.req_valid_in = NUM_REQ'(1) << idx;
        bus.req_mode_in  = MODE_W'(mode) << (2 * idx);
        #1;
        check("job_ready", 32'(bus.req_ready_out), 32'(1) << idx);
        t = cyc;
        done_cyc = (n_run > 0) ? t + n_run + 4 : t + TIMEOUT_CYCLES + 4;
        sb_q.push_back('{idx, exp_st, done_cyc});
        next_cycle();
        bus.req_valid_in = '0;
        bus.req_mode_in  = '1;
        #1;
        check("job_ctrl_issue", 32'(aes_ctrl_out), 32'(exp_ctrl));
        check("job_busy", 32'(busy_out), 32'(1));
        check("job_grant", 32'(grant_id_out), 32'(idx));
        repeat ((n_run > 0) ? n_run : TIMEOUT_CYCLES) next_cycle();
        aes_complete_in = (n_run > 0);
        #1;
        check("job_ctrl_run", 32'(aes_ctrl_out), 32'(exp_ctrl));
        next_cycle();
        aes_complete_in = 1'b0;
        #1;
        check("job_ctrl_clear", 32'(aes_ctrl_out), 32'(0));
        while (cyc <= done_cyc) next_cycle();
        #1;
        check("job_idle", 32'(busy_out), 32'(0));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        rst_n_in         = 1'b0;
        aes_complete_in  = 1'b0;
        init_fault       = 1'b0;
        bus.req_valid_in = '0;
        bus.req_mode_in  = '0;
        next_cycle();
        next_cycle();
        check("rst_ctrl", 32'(aes_ctrl_out), 32'(0));
        check("rst_busy", 32'(busy_out), 32'(0));
        check("rst_grant", 32'(grant_id_out), 32'(0));
        check("rst_done", 32'(bus.done_valid_out), 32'(0));
        check("rst_status", 32'(bus.done_status_out), 32'(0));
        rst_n_in = 1'b1;
        next_cycle();

        // Single encrypt, complete seen at cycle 6, done at cycle 9.
        job(0, MODE_ENC, 5, ST_OK);

        // Bad mode from requester 1: done the very next cycle, engine never driven.
        bus.req_valid_in = 2'b10;
        bus.req_mode_in  = 4'b1100;
        #1;
        check("bad_ready", 32'(bus.req_ready_out), 32'(2));
        sb_q.push_back('{1, ST_BAD_MODE, cyc + 1});
        next_cycle();
        bus.req_valid_in = '0;
        #1;
        check("bad_ctrl", 32'(aes_ctrl_out), 32'(0));
        check("bad_busy", 32'(busy_out), 32'(1));
        check("bad_grant", 32'(grant_id_out), 32'(1));
        next_cycle();
        #1;
        check("bad_ctrl_after", 32'(aes_ctrl_out), 32'(0));
        check("bad_idle", 32'(busy_out), 32'(0));

        // Round-robin: both valid continuously; pointer returned to 0 after the bad-mode job.
        bus.req_valid_in = 2'b11;
        bus.req_mode_in  = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            int w;
            logic [1:0] exp_gnt;
            logic [2:0] exp_ctrl;
            w        = 0;
            exp_gnt  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_ctrl = (k % 2 == 0) ? 3'b001 : 3'b010;
            #1;
            while ((bus.req_ready_out == '0) && (w < 20)) begin
                next_cycle();
                w++;
            end
            check("rr_grant", 32'(bus.req_ready_out), 32'(exp_gnt));
            t = cyc;
            sb_q.push_back('{k % 2, ST_OK, t + 7});
            next_cycle();
            #1;
            check("rr_ctrl", 32'(aes_ctrl_out), 32'(exp_ctrl));
            check("rr_grant_id", 32'(grant_id_out), 32'(k % 2));
            repeat (3) next_cycle();
            aes_complete_in = 1'b1;
            next_cycle();
            aes_complete_in = 1'b0;
            #1;
            check("rr_gap0", 32'(aes_ctrl_out), 32'(0));
            next_cycle();
            #1;
            check("rr_gap1", 32'(aes_ctrl_out), 32'(0));
            next_cycle();
        end
        bus.req_valid_in = '0;
        next_cycle();

        // Timeout: complete never arrives, 16 RUN cycles then TIMEOUT.
        job(0, MODE_ENC, 0, ST_TIMEOUT);
        // Next request after a timeout is handled normally.
        job(1, MODE_DEC, 3, ST_OK);
        // Complete on the same cycle the counter hits its last value: complete wins.
        job(0, MODE_ENC, 16, ST_OK);

        // Engine fails to decode the control word in ISSUE.
        init_fault       = 1'b1;
        bus.req_valid_in = 2'b10;
        bus.req_mode_in  = 4'b0100;
        #1;
        check("fault_ready", 32'(bus.req_ready_out), 32'(2));
        t = cyc;
        sb_q.push_back('{1, ST_TIMEOUT, t + 4});
        next_cycle();
        bus.req_valid_in = '0;
        #1;
        check("fault_ctrl_issue", 32'(aes_ctrl_out), 32'(1));
        next_cycle();
        init_fault = 1'b0;
        #1;
        check("fault_ctrl_clear", 32'(aes_ctrl_out), 32'(0));
        while (cyc <= t + 4) next_cycle();
        #1;
        check("fault_idle", 32'(busy_out), 32'(0));

        // Reset mid-RUN: control word drops at once, no done pulse for the aborted job.
        bus.req_valid_in = 2'b01;
        bus.req_mode_in  = 4'b0001;
        #1;
        check("rstrun_ready", 32'(bus.req_ready_out), 32'(1));
        next_cycle();
        bus.req_valid_in = '0;
        repeat (3) next_cycle();
        #1;
        check("rstrun_ctrl_pre", 32'(aes_ctrl_out), 32'(1));
        rst_n_in = 1'b0;
        #1;
        check("rstrun_ctrl", 32'(aes_ctrl_out), 32'(0));
        check("rstrun_busy", 32'(busy_out), 32'(0));
        check("rstrun_done", 32'(bus.done_valid_out), 32'(0));
        next_cycle();
        next_cycle();
        rst_n_in = 1'b1;
        next_cycle();
        #1;
        check("rstrun_idle", 32'(busy_out), 32'(0));
        job(0, MODE_DEC, 2, ST_OK);

        repeat (3) next_cycle();
        check("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
